// File: rtl/udp_rx_arbiter.sv
// Frame-level round-robin arbiter that shares one udpip_receiver among N_PORTS
// byte-stream sources, truncating frames longer than the receiver buffer.
module udp_rx_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int MAX_LEN   = 256,
    parameter int MIN_DRAIN = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*N_PORTS-1:0] src_data,
    input  logic [N_PORTS-1:0]   src_valid,
    input  logic [N_PORTS-1:0]   src_first,
    input  logic [N_PORTS-1:0]   src_last,
    output logic [N_PORTS-1:0]   src_ready,
    input  logic [2:0]           rx_state,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    output logic                 rd_first,
    output logic                 rd_last,
    output logic [2:0]           grant_idx,
    output logic                 busy,
    output logic                 trunc,
    output logic [15:0]          frame_count,
    output logic [15:0]          trunc_count
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FWD     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    localparam int BCNT_W = $clog2(MAX_LEN + 1);
    localparam int DCNT_W = $clog2(MIN_DRAIN + 2);
    localparam logic [BCNT_W-1:0] MAX_LEN_C   = BCNT_W'(MAX_LEN);
    localparam logic [DCNT_W-1:0] MIN_DRAIN_C = DCNT_W'(MIN_DRAIN);

    logic [1:0]         state;
    logic [2:0]         rr_ptr;
    logic [BCNT_W-1:0]  byte_cnt;
    logic [BCNT_W-1:0]  byte_cnt_nxt;
    logic [DCNT_W-1:0]  drain_cnt;

    logic [N_PORTS-1:0] eligible;
    logic [N_PORTS-1:0] grant_onehot;
    logic               any_eligible;
    logic [2:0]         winner;
    logic [2:0]         winner_nxt;
    logic [7:0]         sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic               sel_accept;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign eligible     = src_valid & src_first;
    assign any_eligible = |eligible;
    assign busy         = (state != S_IDLE);
    assign byte_cnt_nxt = byte_cnt + 1'b1;
    assign winner_nxt   = (winner == 3'(N_PORTS - 1)) ? 3'd0 : winner + 3'd1;

    // Round-robin pick: eligible port with the smallest distance above rr_ptr.
    always_comb begin
        int off;
        int best_off;
        off      = 0;
        best_off = N_PORTS;
        winner   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            off = i - int'(rr_ptr);
            if (off < 0) off = off + N_PORTS;
            if (eligible[i] && off < best_off) begin
                best_off = off;
                winner   = 3'(i);
            end
        end
    end

    always_comb begin
        sel_data     = '0;
        sel_valid    = 1'b0;
        sel_last     = 1'b0;
        grant_onehot = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_idx == 3'(i)) begin
                grant_onehot[i] = 1'b1;
                sel_data        = src_data[8*i +: 8];
                sel_valid       = src_valid[i];
                sel_last        = src_last[i];
            end
        end
    end

    // Mid-frame bytes arriving while idle are soaked up so the source resyncs.
    always_comb begin
        src_ready = '0;
        if (rst_n) begin
            case (state)
                S_IDLE:             src_ready = src_valid & ~src_first;
                S_FWD, S_DISCARD:   src_ready = grant_onehot;
                default:            src_ready = '0;
            endcase
        end
    end

    assign sel_accept = sel_valid && (state == S_FWD || state == S_DISCARD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            byte_cnt    <= '0;
            drain_cnt   <= '0;
            grant_idx   <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            rd_first    <= 1'b0;
            rd_last     <= 1'b0;
            trunc       <= 1'b0;
            frame_count <= '0;
            trunc_count <= '0;
        end else begin
            rd_valid <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
            trunc    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_eligible && rx_state == 3'd0) begin
                        grant_idx   <= winner;
                        rr_ptr      <= winner_nxt;
                        frame_count <= sat_inc(frame_count);
                        byte_cnt    <= '0;
                        state       <= S_FWD;
                    end
                end
                S_FWD: begin
                    if (sel_accept) begin
                        rd_data  <= sel_data;
                        rd_valid <= 1'b1;
                        rd_first <= (byte_cnt == '0);
                        byte_cnt <= byte_cnt_nxt;
                        if (sel_last) begin
                            rd_last   <= 1'b1;
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end else if (byte_cnt_nxt == MAX_LEN_C) begin
                            rd_last     <= 1'b1;
                            trunc       <= 1'b1;
                            trunc_count <= sat_inc(trunc_count);
                            state       <= S_DISCARD;
                        end
                    end
                end
                S_DISCARD: begin
                    if (sel_accept && sel_last) begin
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end
                end
                default: begin
                    // rx_state lags the last byte by a cycle, so idle is only trusted after MIN_DRAIN.
                    if (drain_cnt >= MIN_DRAIN_C && rx_state == 3'd0) begin
                        state <= S_IDLE;
                    end else if (drain_cnt < MIN_DRAIN_C) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_udp_rx_arbiter.sv
// Self-checking bench for udp_rx_arbiter: directed scenarios plus randomized
// multi-port traffic compared against a frame-level round-robin model.
module tb_udp_rx_arbiter;
    localparam int N_PORTS   = 4;
    localparam int MAX_LEN   = 256;
    localparam int MIN_DRAIN = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [8*N_PORTS-1:0] src_data = '0;
    logic [N_PORTS-1:0]   src_valid = '0;
    logic [N_PORTS-1:0]   src_first = '0;
    logic [N_PORTS-1:0]   src_last = '0;
    logic [N_PORTS-1:0]   src_ready;
    logic [2:0]           rx_state = '0;
    logic [7:0]           rd_data;
    logic                 rd_valid;
    logic                 rd_first;
    logic                 rd_last;
    logic [2:0]           grant_idx;
    logic                 busy;
    logic                 trunc;
    logic [15:0]          frame_count;
    logic [15:0]          trunc_count;

    udp_rx_arbiter #(.N_PORTS(N_PORTS), .MAX_LEN(MAX_LEN), .MIN_DRAIN(MIN_DRAIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_data(src_data), .src_valid(src_valid), .src_first(src_first),
        .src_last(src_last), .src_ready(src_ready), .rx_state(rx_state),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_first(rd_first), .rd_last(rd_last),
        .grant_idx(grant_idx), .busy(busy), .trunc(trunc),
        .frame_count(frame_count), .trunc_count(trunc_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
    } beat_t;

    beat_t      src_q[N_PORTS][$];
    logic [7:0] exp_bytes[N_PORTS][$];
    int         len_q[N_PORTS][$];
    logic [7:0] cur_bytes[$];

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;
    int mptr = 0;
    int cur_port = -1;
    int last_end_cycle = -1;
    int rdv_count = 0;
    int trunc_pulses = 0;
    int rx_mode = 0;
    logic [2:0] rx_hold = '0;
    bit gaps_en = 1'b1;
    bit mid_first_en = 1'b0;
    bit gap_chk = 1'b0;

    logic [N_PORTS-1:0]   acc_snap;
    logic [N_PORTS-1:0]   rdy_snap;
    logic [8*N_PORTS-1:0] data_snap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic load_frame(input int p, input int len);
        beat_t b;
        len_q[p].push_back(len);
        for (int j = 0; j < len; j++) begin
            b.data  = 8'($urandom);
            b.first = (j == 0) || (mid_first_en && $urandom_range(0, 15) == 0);
            b.last  = (j == len - 1);
            src_q[p].push_back(b);
            exp_bytes[p].push_back(b.data);
        end
    endtask

    task automatic load_junk(input int p, input int n);
        beat_t b;
        for (int j = 0; j < n; j++) begin
            b.data  = 8'($urandom);
            b.first = 1'b0;
            b.last  = (j == n - 1);
            src_q[p].push_back(b);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N_PORTS; i++) begin
            src_q[i].delete();
            exp_bytes[i].delete();
            len_q[i].delete();
        end
        cur_bytes.delete();
        mptr = 0;
        cur_port = -1;
        last_end_cycle = -1;
        rdv_count = 0;
        trunc_pulses = 0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N_PORTS; i++) begin
            if (src_q[i].size() > 0 && (src_q[i][0].first || !gaps_en || $urandom_range(0, 4) != 0)) begin
                src_valid[i]       = 1'b1;
                src_data[8*i +: 8] = src_q[i][0].data;
                src_first[i]       = src_q[i][0].first;
                src_last[i]        = src_q[i][0].last;
            end else begin
                src_valid[i]       = 1'b0;
                src_data[8*i +: 8] = 8'($urandom);
                src_first[i]       = 1'b0;
                src_last[i]        = 1'b0;
            end
        end
        case (rx_mode)
            0:       rx_state = 3'd0;
            1:       rx_state = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            default: rx_state = rx_hold;
        endcase
    endtask

    task automatic monitor();
        int found;
        int exp_port;
        int p;
        int L;
        int explen;
        int mism;
        logic [7:0] b;
        if (trunc) trunc_pulses++;
        if (!rd_valid) return;
        rdv_count++;
        found = 0;
        for (int i = 0; i < N_PORTS; i++)
            if (acc_snap[i] && data_snap[8*i +: 8] == rd_data) found = 1;
        check("latency_one_cycle", found, 1);
        if (cur_bytes.size() == 0) begin
            check("rd_first_on_byte1", rd_first, 1);
            exp_port = -1;
            for (int k = 0; k < N_PORTS; k++) begin
                p = (mptr + k) % N_PORTS;
                if (exp_port < 0 && len_q[p].size() > 0) exp_port = p;
            end
            check("frame_expected", (exp_port >= 0), 1);
            check("grant_idx", grant_idx, exp_port);
            if (exp_port >= 0) mptr = (exp_port + 1) % N_PORTS;
            cur_port = exp_port;
            if (gap_chk && last_end_cycle >= 0)
                check("drain_gap", cycle - last_end_cycle, MIN_DRAIN + 3);
        end else begin
            check("rd_first_mid", rd_first, 0);
        end
        cur_bytes.push_back(rd_data);
        if (rd_last) begin
            if (cur_port >= 0) begin
                L = len_q[cur_port].pop_front();
                explen = (L > MAX_LEN) ? MAX_LEN : L;
                check("frame_len", cur_bytes.size(), explen);
                mism = 0;
                for (int j = 0; j < L; j++) begin
                    b = exp_bytes[cur_port].pop_front();
                    if (j < explen && j < cur_bytes.size() && cur_bytes[j] != b) mism++;
                end
                check("frame_data_mismatches", mism, 0);
                check("trunc_with_forced_last", trunc, (L > MAX_LEN));
            end
            cur_bytes.delete();
            cur_port = -1;
            last_end_cycle = cycle;
        end
    endtask

    task automatic step();
        drive_inputs();
        #1;
        acc_snap  = src_valid & src_ready;
        rdy_snap  = src_ready;
        data_snap = src_data;
        @(posedge clk);
        @(negedge clk);
        cycle++;
        for (int i = 0; i < N_PORTS; i++)
            if (acc_snap[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        monitor();
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N_PORTS; i++)
            if (src_q[i].size() > 0 || len_q[i].size() > 0) return 1'b0;
        return !busy && cur_bytes.size() == 0;
    endfunction

    task automatic run_until_done(input string tag, input int budget);
        for (int n = 0; n < budget && !all_done(); n++) step();
        check({tag, "_completed"}, all_done(), 1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_model();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_first"}, rd_first, 0);
        check({tag, "_rd_last"}, rd_last, 0);
        check({tag, "_src_ready"}, src_ready, 0);
        check({tag, "_grant_idx"}, grant_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_trunc"}, trunc, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_trunc_count"}, trunc_count, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int total;
        int ntrunc;
        int len;
        int r;

        // Reset state, then a single 30-byte frame on port 0.
        clear_model();
        repeat (3) step();
        check_reset("reset");
        rst_n = 1'b1;
        load_frame(0, 30);
        run_until_done("single30", 500);
        check("single30_frame_count", frame_count, 1);
        check("single30_beats", rdv_count, 30);

        // Ports 0 and 1 request together: 0 first, 1 after DRAIN.
        reset_dut();
        gap_chk = 1'b1;
        load_frame(0, 20);
        load_frame(1, 15);
        run_until_done("two_ports", 500);
        gap_chk = 1'b0;
        check("two_ports_frame_count", frame_count, 2);

        // 300-byte frame is cut at MAX_LEN and the tail discarded.
        reset_dut();
        load_frame(0, 300);
        run_until_done("long300", 2000);
        check("long300_trunc_count", trunc_count, 1);
        check("long300_trunc_pulses", trunc_pulses, 1);
        check("long300_beats", rdv_count, MAX_LEN);
        check("long300_frame_count", frame_count, 1);

        // Receiver busy: no grant for 50 cycles, grant on first idle cycle.
        reset_dut();
        rx_mode = 2;
        rx_hold = 3'd3;
        load_frame(2, 8);
        bad = 0;
        repeat (50) begin
            step();
            if (rdy_snap[2] || busy) bad++;
        end
        check("hold_no_grant_cycles", bad, 0);
        rx_mode = 0;
        step();
        check("hold_release_busy", busy, 1);
        check("hold_release_grant", grant_idx, 2);
        run_until_done("hold", 500);
        check("hold_frame_count", frame_count, 1);

        // Headless bytes in IDLE are accepted and dropped.
        reset_dut();
        load_junk(3, 5);
        run_until_done("junk", 200);
        check("junk_frame_count", frame_count, 0);
        check("junk_beats", rdv_count, 0);

        // Asynchronous reset in the middle of a frame.
        reset_dut();
        load_frame(1, 40);
        for (int n = 0; n < 300 && cur_bytes.size() < 10; n++) step();
        check("midrst_reached_byte10", cur_bytes.size(), 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        clear_model();
        @(negedge clk);
        repeat (2) step();
        rst_n = 1'b1;
        load_frame(2, 12);
        run_until_done("after_midrst", 500);
        check("after_midrst_frame_count", frame_count, 1);

        // Randomized multi-port traffic with a busy receiver.
        reset_dut();
        rx_mode = 1;
        mid_first_en = 1'b1;
        total = 0;
        ntrunc = 0;
        for (int p = 0; p < N_PORTS; p++) begin
            for (int f = 0; f < int'($urandom_range(2, 4)); f++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      len = int'($urandom_range(MAX_LEN + 1, MAX_LEN + 44));
                else if (r == 1) len = 1;
                else if (r == 2) len = MAX_LEN;
                else             len = int'($urandom_range(2, 60));
                load_frame(p, len);
                total++;
                if (len > MAX_LEN) ntrunc++;
            end
        end
        run_until_done("random", 30000);
        check("random_frame_count", frame_count, total);
        check("random_trunc_count", trunc_count, ntrunc);
        check("random_trunc_pulses", trunc_pulses, ntrunc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
